// File: rtl/ws_pkg.sv
// ---------------------------------------------------------------------------
// ws_pkg
// Shared types for the weight-stationary systolic feeder.
//   ws_state_e : sequencer phase (IDLE, PRELOAD, STREAM, DRAIN)
//   OP_PRELOAD : op_sel value while kernel words shift into the array
//   OP_CONV    : op_sel value while fmap vectors stream through the array
// ---------------------------------------------------------------------------
package ws_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRELOAD = 2'd1,
    STREAM  = 2'd2,
    DRAIN   = 2'd3
  } ws_state_e;

  localparam logic OP_PRELOAD = 1'b0;
  localparam logic OP_CONV    = 1'b1;

endpackage

// File: rtl/ws_skew_lane.sv
// ---------------------------------------------------------------------------
// ws_skew_lane
// DEPTH-stage shift register carrying one fmap word plus its valid bit.
// Lane c of the feeder uses DEPTH = c+1, which produces the diagonal skew.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset (clears every stage)
//   in_data   : word entering stage 0 (zero when no vector is accepted)
//   in_vld    : valid entering stage 0
//   out_data  : word leaving the last stage
//   out_vld   : valid leaving the last stage
// ---------------------------------------------------------------------------
module ws_skew_lane #(
  parameter int DEPTH = 1,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_vld,
  output logic [W-1:0] out_data,
  output logic         out_vld
);

  logic [W-1:0]     data_p [DEPTH];
  logic [DEPTH-1:0] vld_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_p[i] <= '0;
      end
      vld_p <= '0;
    end else begin
      data_p[0] <= in_data;
      vld_p[0]  <= in_vld;
      for (int i = 1; i < DEPTH; i++) begin
        data_p[i] <= data_p[i-1];
        vld_p[i]  <= vld_p[i-1];
      end
    end
  end

  assign out_data = data_p[DEPTH-1];
  assign out_vld  = vld_p[DEPTH-1];

endmodule

// File: rtl/ws_systolic_feeder.sv
// ---------------------------------------------------------------------------
// ws_systolic_feeder
// Sequencer in front of the weight-stationary systolic array. A job preloads
// COLUMN kernel words (op_sel = 0), then streams num_vectors im2row vectors
// (op_sel = 1) through a diagonal skew (lane c delayed c extra cycles), then
// pushes COLUMN zero cycles to flush the skew and pulses done.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   start, num_vectors  : job launch pulse and vector count (sampled on accept)
//   k_valid/k_ready/k_data : kernel word handshake, array shift order
//   f_valid/f_ready/f_data : fmap vector handshake, lane c = [c*W +: W]
//   kernel_out, op_sel  : to array kernel_in / Op_sel
//   fmap_out, lane_valid: skewed lanes and their per-lane valid
//   busy, done          : job in flight / one-cycle completion pulse
// busy stays high through the done cycle so a start issued in that cycle
// continues straight into the next job without a busy gap.
// ---------------------------------------------------------------------------
module ws_systolic_feeder
  import ws_pkg::*;
#(
  parameter int IN_WORD_SIZE = 16,
  parameter int COLUMN       = 4,
  parameter int CNT_W        = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CNT_W-1:0]               num_vectors,
  input  logic                           k_valid,
  output logic                           k_ready,
  input  logic [IN_WORD_SIZE-1:0]        k_data,
  input  logic                           f_valid,
  output logic                           f_ready,
  input  logic [COLUMN*IN_WORD_SIZE-1:0] f_data,
  output logic [IN_WORD_SIZE-1:0]        kernel_out,
  output logic                           op_sel,
  output logic [COLUMN*IN_WORD_SIZE-1:0] fmap_out,
  output logic [COLUMN-1:0]              lane_valid,
  output logic                           busy,
  output logic                           done
);

  localparam int KCNT_W = $clog2(COLUMN + 1);
  localparam logic [KCNT_W-1:0] K_FULL = KCNT_W'(COLUMN);
  localparam logic [KCNT_W-1:0] D_LAST = KCNT_W'(COLUMN - 1);

  ws_state_e         state_q, state_d;
  logic [KCNT_W-1:0] kcnt_q, dcnt_q;
  logic [CNT_W-1:0]  vcnt_q, num_q;
  logic [CNT_W:0]    vcnt_inc;
  logic              accept, k_fire, f_fire, last_vec, drain_end;

  logic [COLUMN-1:0][IN_WORD_SIZE-1:0] lane_in;

  assign accept    = start && (state_q == IDLE);
  assign k_fire    = k_valid && k_ready;
  assign f_fire    = f_valid && f_ready;
  // One bit wider than the count so num_vectors = 2^CNT_W-1 compares cleanly.
  assign vcnt_inc  = {1'b0, vcnt_q} + (CNT_W+1)'(1);
  assign last_vec  = f_fire && (vcnt_inc == {1'b0, num_q});
  assign drain_end = (state_q == DRAIN) && (dcnt_q == D_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = PRELOAD;
      // The extra cycle at kcnt == COLUMN lets kernel_out return to zero
      // before op_sel flips, so the array never sees a weight in convolve mode.
      PRELOAD: if (kcnt_q == K_FULL) state_d = (num_q == '0) ? DRAIN : STREAM;
      STREAM:  if (last_vec) state_d = DRAIN;
      DRAIN:   if (drain_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    k_ready = (state_q == PRELOAD) && (kcnt_q != K_FULL);
    f_ready = (state_q == STREAM);
    op_sel  = ((state_q == STREAM) || (state_q == DRAIN)) ? OP_CONV : OP_PRELOAD;
  end

  // ---- job counters, kernel register, busy/done ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kcnt_q     <= '0;
      vcnt_q     <= '0;
      dcnt_q     <= '0;
      num_q      <= '0;
      kernel_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      kernel_out <= k_fire ? k_data : '0;
      done       <= drain_end;
      if (accept)    busy <= 1'b1;
      else if (done) busy <= 1'b0;
      if (accept) begin
        num_q  <= num_vectors;
        kcnt_q <= '0;
        vcnt_q <= '0;
        dcnt_q <= '0;
      end else begin
        if (k_fire) kcnt_q <= kcnt_q + KCNT_W'(1);
        if (f_fire) vcnt_q <= vcnt_inc[CNT_W-1:0];
        if (state_q == DRAIN) dcnt_q <= drain_end ? '0 : dcnt_q + KCNT_W'(1);
      end
    end
  end

  // ---- skew: lane c passes through c+1 register stages ----
  for (genvar c = 0; c < COLUMN; c++) begin : g_lane
    // Without a handshake a zero bubble enters so gaps stay aligned per lane.
    assign lane_in[c] = f_fire ? f_data[c*IN_WORD_SIZE +: IN_WORD_SIZE] : '0;

    ws_skew_lane #(
      .DEPTH (c + 1),
      .W     (IN_WORD_SIZE)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .in_data  (lane_in[c]),
      .in_vld   (f_fire),
      .out_data (fmap_out[c*IN_WORD_SIZE +: IN_WORD_SIZE]),
      .out_vld  (lane_valid[c])
    );
  end

endmodule

// File: tb/tb_ws_systolic_feeder.sv
module tb_ws_systolic_feeder;

  localparam int W      = 16;
  localparam int COLUMN = 4;
  localparam int CNT_W  = 8;
  localparam int DW     = COLUMN * W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic             k_valid = 1'b0;
  logic             k_ready;
  logic [W-1:0]     k_data = '0;
  logic             f_valid = 1'b0;
  logic             f_ready;
  logic [DW-1:0]    f_data = '0;
  logic [W-1:0]     kernel_out;
  logic             op_sel;
  logic [DW-1:0]    fmap_out;
  logic [COLUMN-1:0] lane_valid;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  ws_systolic_feeder #(
    .IN_WORD_SIZE (W),
    .COLUMN       (COLUMN),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_vectors (num_vectors),
    .k_valid     (k_valid),
    .k_ready     (k_ready),
    .k_data      (k_data),
    .f_valid     (f_valid),
    .f_ready     (f_ready),
    .f_data      (f_data),
    .kernel_out  (kernel_out),
    .op_sel      (op_sel),
    .fmap_out    (fmap_out),
    .lane_valid  (lane_valid),
    .busy        (busy),
    .done        (done)
  );

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: job phase plus counts, and the skew expressed as a
  // history of what was injected each cycle (lane c shows the entry from
  // c cycles before the newest one).
  // ---------------------------------------------------------------------
  int ph;  // 0 idle, 1 preload, 2 stream, 3 drain
  int kc, vc, dc, nv;
  logic [W-1:0]  e_kernel;
  logic          e_done, e_busy;
  logic [DW-1:0] hd [$];
  bit            hv [$];

  task automatic model_reset();
    ph = 0; kc = 0; vc = 0; dc = 0; nv = 0;
    e_kernel = '0; e_done = 1'b0; e_busy = 1'b0;
    hd = {}; hv = {};
    for (int i = 0; i < COLUMN; i++) begin
      hd.push_back('0);
      hv.push_back(1'b0);
    end
  endtask

  task automatic model_step();
    bit kr, fr, kf, ff, was_done;
    kr = (ph == 1) && (kc < COLUMN);
    fr = (ph == 2);
    kf = k_valid && kr;
    ff = f_valid && fr;
    hd.push_front(ff ? f_data : '0);
    hv.push_front(ff);
    void'(hd.pop_back());
    void'(hv.pop_back());
    e_kernel = kf ? k_data : '0;
    was_done = e_done;
    e_done   = (ph == 3) && (dc == COLUMN - 1);
    if ((ph == 0) && start) e_busy = 1'b1;
    else if (was_done)      e_busy = 1'b0;
    case (ph)
      0: if (start) begin nv = int'(num_vectors); kc = 0; vc = 0; ph = 1; end
      1: if (kc == COLUMN) begin ph = (nv == 0) ? 3 : 2; dc = 0; end
         else if (kf) kc++;
      2: if (ff) begin
           vc++;
           if (vc == nv) begin ph = 3; dc = 0; end
         end
      default: if (dc == COLUMN - 1) ph = 0; else dc++;
    endcase
  endtask

  task automatic model_compare();
    logic [DW-1:0]     ef, tmp;
    logic [COLUMN-1:0] ev;
    ef = '0; ev = '0;
    for (int c = 0; c < COLUMN; c++) begin
      tmp = hd[c];
      ef[c*W +: W] = tmp[c*W +: W];
      ev[c] = hv[c];
    end
    chk("m_kernel_out", DW'(kernel_out), DW'(e_kernel));
    chk("m_k_ready", DW'(k_ready), DW'((ph == 1) && (kc < COLUMN)));
    chk("m_f_ready", DW'(f_ready), DW'(ph == 2));
    chk("m_op_sel", DW'(op_sel), DW'(ph >= 2));
    chk("m_busy", DW'(busy), DW'(e_busy));
    chk("m_done", DW'(done), DW'(e_done));
    chk("m_lane_valid", DW'(lane_valid), DW'(ev));
    chk("m_fmap_out", fmap_out, ef);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
      #1;
      model_compare();
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus with hand-computed expectations
  // ---------------------------------------------------------------------
  logic [W-1:0]      kw [4];
  logic [DW-1:0]     vec [4];
  logic [COLUMN-1:0] lv_exp [9];
  logic [COLUMN-1:0] rec [10];
  logic              rdone [10];
  bit [0:5]          pin_v;
  bit [0:9]          pat_v;

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, DW'(busy), '0);
    chk({tag, "_done"}, DW'(done), '0);
    chk({tag, "_op_sel"}, DW'(op_sel), '0);
    chk({tag, "_k_ready"}, DW'(k_ready), '0);
    chk({tag, "_f_ready"}, DW'(f_ready), '0);
    chk({tag, "_kernel_out"}, DW'(kernel_out), '0);
    chk({tag, "_fmap_out"}, fmap_out, '0);
    chk({tag, "_lane_valid"}, DW'(lane_valid), '0);
  endtask

  initial begin
    int rise, didx, waited, ones;
    bit fr_seen;
    logic [9:0] got, exp;

    kw[0] = 16'h05; kw[1] = 16'h04; kw[2] = 16'h02; kw[3] = 16'h03;
    vec[0] = {16'hc3, 16'hf5, 16'h8e, 16'ha3};
    vec[1] = {16'h82, 16'hc3, 16'hc5, 16'h8e};
    vec[2] = {16'h66, 16'ha5, 16'hc3, 16'hf5};
    vec[3] = {16'h25, 16'h66, 16'h82, 16'hc3};
    lv_exp[0] = 4'b0000; lv_exp[1] = 4'b0001; lv_exp[2] = 4'b0011;
    lv_exp[3] = 4'b0111; lv_exp[4] = 4'b1111; lv_exp[5] = 4'b1110;
    lv_exp[6] = 4'b1100; lv_exp[7] = 4'b1000; lv_exp[8] = 4'b0000;
    pin_v = 6'b110011;
    pat_v = 10'b1100110000;

    // reset state
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rst = 1'b1;

    // job 1: preload 05,04,02,03 then four back-to-back vectors
    @(negedge clk);
    start = 1'b1; num_vectors = 8'd4;
    @(negedge clk);
    start = 1'b0;
    chk("j1_busy", DW'(busy), 1);
    chk("j1_k_ready", DW'(k_ready), 1);
    k_valid = 1'b1; k_data = kw[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("j1_kernel_out", DW'(kernel_out), DW'(kw[i]));
      chk("j1_op_sel_pre", DW'(op_sel), 0);
      if (i < 3) k_data = kw[i+1];
      else       k_valid = 1'b0;
    end
    @(negedge clk);
    chk("j1_kernel_zero", DW'(kernel_out), 0);
    chk("j1_op_sel_conv", DW'(op_sel), 1);
    chk("j1_f_ready", DW'(f_ready), 1);
    chk("j1_k_ready_off", DW'(k_ready), 0);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      chk("j1_diag", DW'(lane_valid), DW'(lv_exp[k]));
      chk("j1_done", DW'(done), DW'(k == 8));
      if (k == 1) chk("j1_lane0_a3", DW'(fmap_out[W-1:0]), 16'ha3);
      if (k == 2) chk("j1_lane1_8e", DW'(fmap_out[W +: W]), 16'h8e);
      if (k == 4) chk("j1_lane3_c3", DW'(fmap_out[DW-1 -: W]), 16'hc3);
      if (k == 4) chk("j1_f_ready_drop", DW'(f_ready), 0);
      if (k < 4) begin f_valid = 1'b1; f_data = vec[k]; end
      else       f_valid = 1'b0;
    end
    // done cycle: launch the next job back-to-back
    chk("b2b_busy_done", DW'(busy), 1);
    start = 1'b1; num_vectors = 8'd4;

    // job 2: back-to-back start, vectors with a 2-cycle bubble
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", DW'(busy), 1);
    chk("b2b_op_sel", DW'(op_sel), 0);
    chk("b2b_k_ready", DW'(k_ready), 1);
    k_valid = 1'b1; k_data = W'($urandom);
    repeat (3) begin @(negedge clk); k_data = W'($urandom); end
    @(negedge clk); k_valid = 1'b0;
    @(negedge clk);
    chk("j2_f_ready", DW'(f_ready), 1);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) begin
        @(negedge clk);
        rec[k-1] = lane_valid;
        rdone[k-1] = done;
      end
      f_valid = (k < 6) ? pin_v[k] : 1'b0;
      f_data = {$urandom, $urandom};
    end
    for (int c = 0; c < COLUMN; c++) begin
      for (int j = 0; j < 10; j++) begin
        got[j] = rec[j][c];
        exp[j] = (j >= c) ? pat_v[j-c] : 1'b0;
      end
      chk($sformatf("bub_lane%0d", c), DW'(got), DW'(exp));
    end
    ones = 0;
    for (int j = 0; j < 10; j++) ones += int'(rec[j][0]);
    chk("bub_accepted", DW'(ones), 4);
    chk("bub_done_early", DW'(rdone[8]), 0);
    chk("bub_done", DW'(rdone[9]), 1);

    // zero-length job: op_sel is high COLUMN cycles, done is the next one
    @(negedge clk);
    start = 1'b1; num_vectors = 8'd0; k_valid = 1'b1; k_data = W'($urandom);
    rise = -1; didx = -1; fr_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start = 1'b0; k_data = W'($urandom);
      if (op_sel && rise < 0) rise = i;
      if (done && didx < 0) didx = i;
      if (f_ready) fr_seen = 1'b1;
    end
    k_valid = 1'b0;
    chk("zl_rise_seen", DW'(rise >= 0), 1);
    chk("zl_done_seen", DW'(didx >= 0), 1);
    chk("zl_done_gap", DW'(didx - rise), COLUMN);
    chk("zl_f_ready_never", DW'(fr_seen), 0);

    // reset in the middle of STREAM
    @(negedge clk);
    start = 1'b1; num_vectors = 8'd8; k_valid = 1'b1; k_data = W'($urandom);
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!f_ready && waited < 20) begin @(negedge clk); waited++; end
    chk("rs_reach_stream", DW'(f_ready), 1);
    k_valid = 1'b0; f_valid = 1'b1; f_data = {$urandom, $urandom};
    @(negedge clk); f_data = {$urandom, $urandom};
    @(negedge clk);
    #2 rst = 1'b0;
    #3 chk_all_zero("rs_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; f_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rs_no_done", DW'(done), 0);
    end

    // randomized traffic, including starts while busy
    for (int n = 0; n < 2500; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 15) == 0);
      num_vectors = CNT_W'($urandom_range(0, 6));
      k_valid = ($urandom_range(0, 9) < 8);
      k_data = W'($urandom);
      f_valid = ($urandom_range(0, 9) < 7);
      f_data = {$urandom, $urandom};
    end
    @(negedge clk);
    start = 1'b0;
    k_valid = 1'b1;
    f_valid = 1'b1;
    waited = 0;
    while (busy && waited < 600) begin @(negedge clk); waited++; end
    chk("rand_idle", DW'(busy), 0);
    k_valid = 1'b0; f_valid = 1'b0;

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
